// File: rtl/ocm_arb_pkg.sv
// Shared defaults and types for the two-master on-chip memory arbiter.
package ocm_arb_pkg;

    localparam int              ADDR_W   = 15;
    localparam int              DATA_W   = 32;
    localparam int              BE_W     = DATA_W / 8;
    localparam int              DEPTH    = 25000;
    localparam logic [31:0]     ERR_DATA = 32'hDEADBEEF;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
module rr_arb2
    import ocm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_t last_grant;

    always_comb begin
        // NOTE: default assignment first so every path drives gnt and no latch is inferred.
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last_grant == OWN_M1) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Reset to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            last_grant <= OWN_M1;
        end else if (gnt[1]) begin
            last_grant <= OWN_M1;
        end else if (gnt[0]) begin
            last_grant <= OWN_M0;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of a single-port on-chip memory.
// Define OCM_ARB_RANGE_CHECK_EN to block accesses at or above DEPTH and flag them on range_err.
module onchip_mem_arbiter
    import ocm_arb_pkg::*;
#(
    parameter int ADDR_W = ocm_arb_pkg::ADDR_W,
    parameter int DATA_W = ocm_arb_pkg::DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              range_err
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              granted;
    logic              fwd;
    owner_t            sel_owner;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_pending;
    owner_t            rd_owner;

    // A write request takes priority over a simultaneous read from the same master.
    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    assign granted        = |gnt;
    assign sel_owner      = gnt[1] ? OWN_M1 : OWN_M0;
    assign sel_write      = gnt[1] ? m1_write      : m0_write;
    assign sel_address    = gnt[1] ? m1_address    : m0_address;
    assign sel_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
    assign sel_writedata  = gnt[1] ? m1_writedata  : m0_writedata;

    assign m0_waitrequest = req[0] & ~gnt[0];
    assign m1_waitrequest = req[1] & ~gnt[1];

`ifdef OCM_ARB_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic in_range;
    logic oor_access;
    logic rd_err;
    logic range_err_q;

    assign in_range   = {1'b0, sel_address} < DEPTH_LIM;
    assign fwd        = granted & in_range;
    assign oor_access = granted & ~in_range;

    // Out-of-range reads still complete through the normal return slot, with ERR_DATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_err      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            rd_err <= oor_access & ~sel_write;
            if (oor_access) begin
                range_err_q <= 1'b1;
            end
        end
    end

    assign rd_data   = rd_err ? DATA_W'(ERR_DATA) : mem_readdata;
    assign range_err = range_err_q;
`else
    assign fwd       = granted;
    assign rd_data   = mem_readdata;
    assign range_err = 1'b0;
`endif

    assign mem_chipselect = fwd;
    assign mem_write      = fwd & sel_write;
    assign mem_address    = fwd ? sel_address    : '0;
    assign mem_byteenable = fwd ? sel_byteenable : '0;
    assign mem_writedata  = fwd ? sel_writedata  : '0;
    assign mem_clken      = 1'b1;

    // One-deep return pipeline matching the memory's single-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_M0;
        end else begin
            rd_pending <= granted & ~sel_write;
            if (granted) begin
                rd_owner <= sel_owner;
            end
        end
    end

    assign m0_readdata      = rd_data;
    assign m1_readdata      = rd_data;
    assign m0_readdatavalid = rd_pending & (rd_owner == OWN_M0);
    assign m1_readdatavalid = rd_pending & (rd_owner == OWN_M1);

endmodule
